// File: rtl/tlul_adapter_host_if.sv
// Bus bundle between an internal word initiator, the host adapter, and the
// TL-UL crossbar host port. The adapter side uses the slave modport.
interface tlul_adapter_host_if;
    // Initiator request side
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;

    // Initiator response side
    logic        valid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    // TL-UL bundles: h2d towards the crossbar, d2h from the crossbar
    logic [101:0] tl_o;
    logic [67:0]  tl_i;

    modport slave (
        input  req_i,
        input  addr_i,
        input  we_i,
        input  wdata_i,
        input  be_i,
        input  tl_i,
        output gnt_o,
        output valid_o,
        output rdata_o,
        output err_o,
        output tl_o
    );

    modport master (
        output req_i,
        output addr_i,
        output we_i,
        output wdata_i,
        output be_i,
        output tl_i,
        input  gnt_o,
        input  valid_o,
        input  rdata_o,
        input  err_o,
        input  tl_o
    );
endinterface

// File: rtl/tlul_adapter_host.sv
// Host-side TL-UL bridge: turns a word request/grant interface into TL-UL
// A-channel requests and D-channel responses into a valid/rdata/err strobe.
// Up to MAX_REQS requests may be outstanding; responses return in order.
// Optional: define TLUL_ADAPTER_HOST_RSP_CHECK_EN to flag out-of-order source
// IDs and spurious responses on err_o.
module tlul_adapter_host #(
    parameter int unsigned MAX_REQS = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    tlul_adapter_host_if.slave bus
);

    localparam int unsigned CNTW = $clog2(MAX_REQS + 1);
    localparam int unsigned IDW  = (MAX_REQS > 1) ? $clog2(MAX_REQS) : 1;
    localparam int unsigned SRCW = 8;

    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(MAX_REQS);
    localparam logic [IDW-1:0]  ID_LAST  = IDW'(MAX_REQS - 1);

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    typedef struct packed {
        logic            a_valid;
        logic [2:0]      a_opcode;
        logic [2:0]      a_param;
        logic [1:0]      a_size;
        logic [SRCW-1:0] a_source;
        logic [31:0]     a_address;
        logic [3:0]      a_mask;
        logic [31:0]     a_data;
        logic [15:0]     a_user;
        logic            d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic            d_valid;
        logic [2:0]      d_opcode;
        logic [2:0]      d_param;
        logic [1:0]      d_size;
        logic [SRCW-1:0] d_source;
        logic            d_sink;
        logic [31:0]     d_data;
        logic [15:0]     d_user;
        logic            d_error;
        logic            a_ready;
    } tl_d2h_t;

    tl_h2d_t h2d;
    tl_d2h_t d2h;

    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [IDW-1:0]  issue_id_q, issue_id_d;

    logic a_valid_c;
    logic a_hs;
    logic d_hs;
    logic rsp_chk_err;

    assign d2h = bus.tl_i;

    // Handshake qualifiers; the request is held off while the window is full
    assign a_valid_c = bus.req_i && (cnt_q != CNT_FULL);
    assign a_hs      = a_valid_c && d2h.a_ready;
    assign d_hs      = d2h.d_valid;

    // A-channel request formation, purely combinational from the initiator
    always_comb begin
        h2d           = '0;
        h2d.a_valid   = a_valid_c;
        h2d.a_param   = 3'd0;
        h2d.a_size    = 2'd2;
        h2d.a_source  = SRCW'(issue_id_q);
        h2d.a_address = {bus.addr_i[31:2], 2'b00};
        h2d.a_user    = 16'h0;
        h2d.d_ready   = 1'b1;
        if (!bus.we_i) begin
            h2d.a_opcode = OP_GET;
            h2d.a_mask   = 4'hF;
            h2d.a_data   = 32'h0;
        end else begin
            h2d.a_opcode = (bus.be_i == 4'hF) ? OP_PUT_FULL : OP_PUT_PARTIAL;
            h2d.a_mask   = bus.be_i;
            h2d.a_data   = bus.wdata_i;
        end
    end

    assign bus.tl_o  = h2d;
    assign bus.gnt_o = a_hs;

    // Outstanding count: simultaneous A and D cancel, never drops below 0
    always_comb begin
        cnt_d = cnt_q;
        if (a_hs && !d_hs) begin
            cnt_d = cnt_q + CNTW'(1);
        end else if (!a_hs && d_hs && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNTW'(1);
        end
    end

    // Source ID for the next request, wrapping explicitly at MAX_REQS
    always_comb begin
        issue_id_d = issue_id_q;
        if (a_hs) begin
            issue_id_d = (issue_id_q == ID_LAST) ? '0 : issue_id_q + IDW'(1);
        end
    end

    // Outstanding count and issue ID registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            issue_id_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            issue_id_q <= issue_id_d;
        end
    end

`ifdef TLUL_ADAPTER_HOST_RSP_CHECK_EN
    logic [IDW-1:0] exp_id_q, exp_id_d;

    // Expected response ID; a spurious response does not consume an ID
    always_comb begin
        exp_id_d = exp_id_q;
        if (d_hs && (cnt_q != '0)) begin
            exp_id_d = (exp_id_q == ID_LAST) ? '0 : exp_id_q + IDW'(1);
        end
    end

    // Expected response ID register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exp_id_q <= '0;
        end else begin
            exp_id_q <= exp_id_d;
        end
    end

    // Flag responses that are out of order or arrive with nothing outstanding
    always_comb begin
        rsp_chk_err = 1'b0;
        if (d_hs) begin
            rsp_chk_err = (d2h.d_source != SRCW'(exp_id_q)) || (cnt_q == '0);
        end
    end

    logic unused_d2h;
    assign unused_d2h = ^{d2h.d_param, d2h.d_size, d2h.d_sink, d2h.d_user,
                          bus.addr_i[1:0]};
`else
    // Response checking is compiled out; err_o reflects d_error only
    always_comb begin
        rsp_chk_err = 1'b0;
    end

    logic unused_d2h;
    assign unused_d2h = ^{d2h.d_param, d2h.d_size, d2h.d_sink, d2h.d_user,
                          d2h.d_source, bus.addr_i[1:0]};
`endif

    // Response strobe, combinational from the D channel
    always_comb begin
        bus.valid_o = d2h.d_valid;
        bus.rdata_o = (d2h.d_opcode == OP_ACK_DATA) ? d2h.d_data : 32'h0;
        bus.err_o   = d2h.d_error || rsp_chk_err;
    end

endmodule

// File: tb/tb_tlul_adapter_host.sv
// Directed bench for tlul_adapter_host: a vector table for single-cycle
// behaviour plus hand-written multi-cycle sequences (window full, A/D in the
// same cycle, ID wrap, reset mid-flight, response checking).
module tb_tlul_adapter_host;

`ifdef TLUL_ADAPTER_HOST_RSP_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tlul_adapter_host_if bus_a ();
    tlul_adapter_host_if bus_b ();

    tlul_adapter_host #(.MAX_REQS(2)) dut_a (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus_a)
    );

    tlul_adapter_host #(.MAX_REQS(3)) dut_b (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus_b)
    );

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        a_ready;
        logic        d_valid;
        logic [2:0]  d_op;
        logic [7:0]  d_src;
        logic [31:0] d_data;
        logic        d_err;
        logic        e_gnt;
        logic        e_avalid;
        logic [2:0]  e_op;
        logic [31:0] e_addr;
        logic [3:0]  e_mask;
        logic [31:0] e_data;
        logic [7:0]  e_src;
        logic        e_valid;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [67:0] mk_d2h(input logic dv, input logic [2:0] dop,
                                           input logic [7:0] dsrc, input logic [31:0] ddata,
                                           input logic derr, input logic ar);
        // Ignored fields carry junk whenever a response is presented
        logic [2:0]  prm;
        logic [1:0]  sz;
        logic        snk;
        logic [15:0] usr;
        prm = dv ? 3'h7 : 3'h0;
        sz  = dv ? 2'h3 : 2'h0;
        snk = dv;
        usr = dv ? 16'hA5A5 : 16'h0;
        return {dv, dop, prm, sz, dsrc, snk, ddata, usr, derr, ar};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic set_a(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic ar,
                         input logic dv, input logic [2:0] dop, input logic [7:0] dsrc,
                         input logic [31:0] ddata, input logic derr);
        bus_a.req_i   = req;
        bus_a.we_i    = we;
        bus_a.be_i    = be;
        bus_a.addr_i  = addr;
        bus_a.wdata_i = wdata;
        bus_a.tl_i    = mk_d2h(dv, dop, dsrc, ddata, derr, ar);
    endtask

    task automatic step_a(input logic req, input logic ar, input logic dv,
                          input logic [2:0] dop, input logic [7:0] dsrc,
                          input logic [31:0] ddata, input logic derr);
        @(negedge clk);
        set_a(req, 1'b0, 4'hF, 32'h0000_0100, 32'h0, ar, dv, dop, dsrc, ddata, derr);
        #1;
    endtask

    task automatic step_b(input logic req, input logic dv, input logic [7:0] dsrc);
        @(negedge clk);
        bus_b.req_i   = req;
        bus_b.we_i    = 1'b0;
        bus_b.be_i    = 4'hF;
        bus_b.addr_i  = 32'h0000_0200;
        bus_b.wdata_i = 32'h0;
        bus_b.tl_i    = mk_d2h(dv, 3'd1, dsrc, 32'h0000_0099, 1'b0, 1'b1);
        #1;
    endtask

    // Reset pulse with checks of the cleared state while reset is held
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk({tag, "_src"}, 32'(bus_a.tl_o[92:85]), 32'h0);
        chk({tag, "_avalid"}, 32'(bus_a.tl_o[101]), 32'(bus_a.req_i));
        @(negedge clk);
        set_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
        bus_b.req_i   = 1'b0;
        bus_b.we_i    = 1'b0;
        bus_b.be_i    = 4'h0;
        bus_b.addr_i  = 32'h0;
        bus_b.wdata_i = 32'h0;
        bus_b.tl_i    = '0;

        // req, addr, we, wdata, be, a_ready, d_valid, d_op, d_src, d_data, d_err,
        // e_gnt, e_avalid, e_op, e_addr, e_mask, e_data, e_src, e_valid, e_rdata, e_err
        vecs[0] = '{1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 3'd0, 8'd0, 32'h0, 1'b0,
                    1'b0, 1'b0, 3'd4, 32'h0, 4'hF, 32'h0, 8'd0, 1'b0, 32'h0, 1'b0};
        vecs[1] = '{1'b1, 32'h1000_0007, 1'b0, 32'hFFFF_FFFF, 4'h0, 1'b1, 1'b0, 3'd0, 8'd0, 32'h0, 1'b0,
                    1'b1, 1'b1, 3'd4, 32'h1000_0004, 4'hF, 32'h0, 8'd0, 1'b0, 32'h0, 1'b0};
        vecs[2] = '{1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 3'd1, 8'd0, 32'hDEAD_BEEF, 1'b0,
                    1'b0, 1'b0, 3'd4, 32'h0, 4'hF, 32'h0, 8'd1, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{1'b1, 32'h2000_0000, 1'b1, 32'h1234_5678, 4'hF, 1'b1, 1'b0, 3'd0, 8'd0, 32'h0, 1'b0,
                    1'b1, 1'b1, 3'd0, 32'h2000_0000, 4'hF, 32'h1234_5678, 8'd1, 1'b0, 32'h0, 1'b0};
        vecs[4] = '{1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 3'd0, 8'd1, 32'hFFFF_FFFF, 1'b1,
                    1'b0, 1'b0, 3'd4, 32'h0, 4'hF, 32'h0, 8'd0, 1'b1, 32'h0, 1'b1};
        vecs[5] = '{1'b1, 32'h3000_0002, 1'b1, 32'hA5A5_0000, 4'h3, 1'b1, 1'b0, 3'd0, 8'd0, 32'h0, 1'b0,
                    1'b1, 1'b1, 3'd1, 32'h3000_0000, 4'h3, 32'hA5A5_0000, 8'd0, 1'b0, 32'h0, 1'b0};
        vecs[6] = '{1'b1, 32'h4000_0000, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, 3'd1, 8'd0, 32'h0000_0011, 1'b0,
                    1'b0, 1'b1, 3'd4, 32'h4000_0000, 4'hF, 32'h0, 8'd1, 1'b1, 32'h0000_0011, 1'b0};
        vecs[7] = '{1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 3'd0, 8'd0, 32'h0, 1'b0,
                    1'b0, 1'b0, 3'd4, 32'h0, 4'hF, 32'h0, 8'd1, 1'b0, 32'h0, 1'b0};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle vectors on the MAX_REQS=2 instance
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_a(vecs[i].req, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata,
                  vecs[i].a_ready, vecs[i].d_valid, vecs[i].d_op, vecs[i].d_src,
                  vecs[i].d_data, vecs[i].d_err);
            #1;
            chk($sformatf("v%0d_gnt", i),    32'(bus_a.gnt_o),          32'(vecs[i].e_gnt));
            chk($sformatf("v%0d_avalid", i), 32'(bus_a.tl_o[101]),      32'(vecs[i].e_avalid));
            chk($sformatf("v%0d_op", i),     32'(bus_a.tl_o[100:98]),   32'(vecs[i].e_op));
            chk($sformatf("v%0d_param", i),  32'(bus_a.tl_o[97:95]),    32'h0);
            chk($sformatf("v%0d_size", i),   32'(bus_a.tl_o[94:93]),    32'h2);
            chk($sformatf("v%0d_src", i),    32'(bus_a.tl_o[92:85]),    32'(vecs[i].e_src));
            chk($sformatf("v%0d_addr", i),   bus_a.tl_o[84:53],         vecs[i].e_addr);
            chk($sformatf("v%0d_mask", i),   32'(bus_a.tl_o[52:49]),    32'(vecs[i].e_mask));
            chk($sformatf("v%0d_data", i),   bus_a.tl_o[48:17],         vecs[i].e_data);
            chk($sformatf("v%0d_user", i),   32'(bus_a.tl_o[16:1]),     32'h0);
            chk($sformatf("v%0d_dready", i), 32'(bus_a.tl_o[0]),        32'h1);
            chk($sformatf("v%0d_valid", i),  32'(bus_a.valid_o),        32'(vecs[i].e_valid));
            chk($sformatf("v%0d_rdata", i),  bus_a.rdata_o,             vecs[i].e_rdata);
            chk($sformatf("v%0d_err", i),    32'(bus_a.err_o),          32'(vecs[i].e_err));
        end

        pulse_reset("rst0");

        // Window fills after two grants; a response frees a slot next cycle
        step_a(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
        chk("bp1_gnt", 32'(bus_a.gnt_o), 32'h1);
        chk("bp1_src", 32'(bus_a.tl_o[92:85]), 32'h0);
        step_a(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
        chk("bp2_gnt", 32'(bus_a.gnt_o), 32'h1);
        chk("bp2_src", 32'(bus_a.tl_o[92:85]), 32'h1);
        step_a(1'b1, 1'b1, 1'b1, 3'd1, 8'd0, 32'h0000_0055, 1'b0);
        chk("bp3_avalid", 32'(bus_a.tl_o[101]), 32'h0);
        chk("bp3_gnt", 32'(bus_a.gnt_o), 32'h0);
        chk("bp3_rdata", bus_a.rdata_o, 32'h0000_0055);
        step_a(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
        chk("bp4_gnt", 32'(bus_a.gnt_o), 32'h1);
        chk("bp4_src", 32'(bus_a.tl_o[92:85]), 32'h0);

        // Drain to one outstanding, then A and D together keep the count at one
        step_a(1'b0, 1'b1, 1'b1, 3'd0, 8'd1, 32'h0, 1'b0);
        chk("sim5_err", 32'(bus_a.err_o), 32'h0);
        step_a(1'b1, 1'b1, 1'b1, 3'd1, 8'd0, 32'h0000_0066, 1'b0);
        chk("sim6_gnt", 32'(bus_a.gnt_o), 32'h1);
        chk("sim6_src", 32'(bus_a.tl_o[92:85]), 32'h1);
        chk("sim6_rdata", bus_a.rdata_o, 32'h0000_0066);
        chk("sim6_err", 32'(bus_a.err_o), 32'h0);
        step_a(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
        chk("sim7_gnt", 32'(bus_a.gnt_o), 32'h1);
        chk("sim7_src", 32'(bus_a.tl_o[92:85]), 32'h0);
        step_a(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
        chk("sim8_full", 32'(bus_a.tl_o[101]), 32'h0);

        // Reset with two outstanding clears the window and the IDs at once
        pulse_reset("rst1");
        step_a(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
        chk("pr1_gnt", 32'(bus_a.gnt_o), 32'h1);
        chk("pr1_src", 32'(bus_a.tl_o[92:85]), 32'h0);
        step_a(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
        chk("pr2_gnt", 32'(bus_a.gnt_o), 32'h1);

        // Out-of-order source, then a matching one, then a spurious response
        step_a(1'b0, 1'b1, 1'b1, 3'd0, 8'd1, 32'h0, 1'b0);
        chk("ooo_err", 32'(bus_a.err_o), 32'(CHK));
        step_a(1'b0, 1'b1, 1'b1, 3'd0, 8'd1, 32'h0, 1'b0);
        chk("inord_err", 32'(bus_a.err_o), 32'h0);
        step_a(1'b0, 1'b1, 1'b1, 3'd0, 8'd0, 32'h0, 1'b0);
        chk("spur_err", 32'(bus_a.err_o), 32'(CHK));
        chk("spur_valid", 32'(bus_a.valid_o), 32'h1);
        step_a(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
        chk("sp1_gnt", 32'(bus_a.gnt_o), 32'h1);
        chk("sp1_src", 32'(bus_a.tl_o[92:85]), 32'h0);
        step_a(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
        chk("sp2_gnt", 32'(bus_a.gnt_o), 32'h1);
        step_a(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
        chk("sp3_full", 32'(bus_a.gnt_o), 32'h0);
        step_a(1'b0, 1'b1, 1'b1, 3'd1, 8'd0, 32'h0000_0077, 1'b0);
        chk("sp4_err", 32'(bus_a.err_o), 32'h0);
        chk("sp4_rdata", bus_a.rdata_o, 32'h0000_0077);
        step_a(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 32'h0, 1'b0);

        // MAX_REQS=3 instance: sources 0,1,2 then full, then wrap to 0
        for (int i = 0; i < 4; i++) begin
            step_b(1'b1, 1'b0, 8'd0);
            chk($sformatf("b%0d_gnt", i), 32'(bus_b.gnt_o), (i < 3) ? 32'h1 : 32'h0);
            if (i < 3) begin
                chk($sformatf("b%0d_src", i), 32'(bus_b.tl_o[92:85]), 32'(i));
            end
        end
        step_b(1'b1, 1'b1, 8'd0);
        chk("b4_avalid", 32'(bus_b.tl_o[101]), 32'h0);
        chk("b4_valid", 32'(bus_b.valid_o), 32'h1);
        step_b(1'b1, 1'b0, 8'd0);
        chk("b5_gnt", 32'(bus_b.gnt_o), 32'h1);
        chk("b5_src", 32'(bus_b.tl_o[92:85]), 32'h0);
        step_b(1'b0, 1'b0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
